// File: rtl/canny_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// canny_pkg : shared constants and types for the Canny frame path
// Rev 1.0
// ---------------------------------------------------------------------------
package canny_pkg;

  localparam int DW             = 24;
  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;
  localparam int STATE_W        = 3;

  typedef logic [31:0] pix_cnt_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CTRL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_PAD    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/canny_out_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// canny_out_stage : one-entry output register draining the edge FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module canny_out_stage
  import canny_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        clear_i,
  input  logic                                        active_i,
  input  pix_cnt_t                                    total_i,
  input  logic                                        empty_i,
  input  logic [BITS_PER_SYMBOL-1:0]                  dout_i,
  input  logic                                        stall_i,
  output logic                                        rd_en_o,
  output logic                                        write_o,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_o,
  output logic                                        eov_o,
  output logic                                        done_o
);

  logic                                        write_q, write_d;
  logic                                        eov_q, eov_d;
  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_q, data_d;
  pix_cnt_t                                    cnt_q, cnt_d;

  always_comb begin
    rd_en_o = active_i & ~empty_i & (~write_q | ~stall_i) & (cnt_q < total_i);
  end

  always_comb begin
    write_d = write_q;
    eov_d   = eov_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (rd_en_o) begin
      write_d = 1'b1;
      data_d  = {SYMBOLS_PER_BEAT{dout_i}};
      cnt_d   = cnt_q + 32'd1;
      eov_d   = (cnt_q + 32'd1 == total_i);
    end else if (!stall_i) begin
      write_d = 1'b0;
      eov_d   = 1'b0;
    end
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      eov_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      write_q <= write_d;
      eov_q   <= eov_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign write_o = write_q;
  assign data_o  = data_q;
  assign eov_o   = eov_q;
  assign done_o  = (cnt_q == total_i) & ~write_q;

endmodule
`default_nettype wire

// File: rtl/canny_frame_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// canny_frame_sequencer : frame FSM, geometry latch and input metering
// Rev 1.0
// ---------------------------------------------------------------------------
module canny_frame_sequencer #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int DEFAULT_WIDTH    = canny_pkg::DEFAULT_WIDTH,
  parameter int DEFAULT_HEIGHT   = canny_pkg::DEFAULT_HEIGHT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        stall_in,
  output logic                                        read,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic                                        end_of_video,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic [3:0]                                  interlaced_in,
  input  logic                                        vip_ctrl_valid,
  input  logic                                        image_full,
  output logic                                        image_wr_en,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] image_din,
  input  logic                                        img_out_empty,
  output logic                                        img_out_rd_en,
  input  logic [BITS_PER_SYMBOL-1:0]                  img_out_dout,
  input  logic                                        stall_out,
  output logic                                        write,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
  output logic                                        end_of_video_out,
  output logic [15:0]                                 width_out,
  output logic [15:0]                                 height_out,
  output logic [3:0]                                  interlaced_out,
  input  logic                                        vip_ctrl_busy,
  output logic                                        vip_ctrl_send,
  output logic                                        err_short,
  output logic                                        err_long
);
  import canny_pkg::*;

  state_e      state_q, state_d;
  pix_cnt_t    in_cnt_q, total_q;
  logic [15:0] width_q, height_q, pend_w_q, pend_h_q;
  logic [3:0]  il_q, pend_il_q;
  logic        err_short_q, err_long_q;

  logic        w_geom_ok, w_accept, w_room, w_out_done;
  logic [15:0] w_apply_w, w_apply_h;
  logic [3:0]  w_apply_il;

  // A geometry arriving in the same cycle as IDLE is used directly.
  assign w_geom_ok  = vip_ctrl_valid & (width_in != 16'd0) & (height_in != 16'd0);
  assign w_apply_w  = w_geom_ok ? width_in      : pend_w_q;
  assign w_apply_h  = w_geom_ok ? height_in     : pend_h_q;
  assign w_apply_il = w_geom_ok ? interlaced_in : pend_il_q;
  assign w_accept   = (state_q == ST_STREAM) & ~image_full & ~stall_in;
  assign w_room     = in_cnt_q < total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_CTRL;
      ST_CTRL:   if (!vip_ctrl_busy) state_d = ST_STREAM;
      ST_STREAM: if (w_accept && end_of_video)
                   state_d = (in_cnt_q + 32'd1 < total_q) ? ST_PAD : ST_DRAIN;
      ST_PAD:    if (in_cnt_q == total_q) state_d = ST_DRAIN;
      ST_DRAIN:  if (w_out_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read          = 1'b0;
    image_wr_en   = 1'b0;
    image_din     = '0;
    vip_ctrl_send = 1'b0;
    case (state_q)
      ST_CTRL:   vip_ctrl_send = ~vip_ctrl_busy;
      ST_STREAM: begin
        read        = ~image_full;
        image_wr_en = w_accept & w_room;
        image_din   = (w_accept & w_room) ? data_in : '0;
      end
      ST_PAD:    image_wr_en = ~image_full & w_room;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_w_q    <= 16'(DEFAULT_WIDTH);
      pend_h_q    <= 16'(DEFAULT_HEIGHT);
      pend_il_q   <= 4'd0;
      width_q     <= 16'(DEFAULT_WIDTH);
      height_q    <= 16'(DEFAULT_HEIGHT);
      il_q        <= 4'd0;
      total_q     <= pix_cnt_t'(DEFAULT_WIDTH * DEFAULT_HEIGHT);
      in_cnt_q    <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      pend_w_q  <= w_apply_w;
      pend_h_q  <= w_apply_h;
      pend_il_q <= w_apply_il;
      if (state_q == ST_IDLE) begin
        width_q  <= w_apply_w;
        height_q <= w_apply_h;
        il_q     <= w_apply_il;
        total_q  <= pix_cnt_t'(w_apply_w) * pix_cnt_t'(w_apply_h);
        in_cnt_q <= '0;
      end else if (image_wr_en) begin
        in_cnt_q <= in_cnt_q + 32'd1;
      end
      if (w_accept && end_of_video && (in_cnt_q + 32'd1 < total_q)) err_short_q <= 1'b1;
      if (w_accept && !w_room) err_long_q <= 1'b1;
    end
  end

  canny_out_stage #(
    .BITS_PER_SYMBOL  (BITS_PER_SYMBOL),
    .SYMBOLS_PER_BEAT (SYMBOLS_PER_BEAT)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == ST_IDLE),
    .active_i ((state_q == ST_STREAM) | (state_q == ST_PAD) | (state_q == ST_DRAIN)),
    .total_i  (total_q),
    .empty_i  (img_out_empty),
    .dout_i   (img_out_dout),
    .stall_i  (stall_out),
    .rd_en_o  (img_out_rd_en),
    .write_o  (write),
    .data_o   (data_out),
    .eov_o    (end_of_video_out),
    .done_o   (w_out_done)
  );

  assign width_out      = width_q;
  assign height_out     = height_q;
  assign interlaced_out = il_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;

endmodule
`default_nettype wire

// File: tb/tb_canny_frame_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_canny_frame_sequencer : directed bench with a passthrough FIFO model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_canny_frame_sequencer;
  localparam int DWT = canny_pkg::DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_in = 1'b1, end_of_video = 1'b0, vip_ctrl_valid = 1'b0;
  logic image_full = 1'b0, stall_out = 1'b0, vip_ctrl_busy = 1'b1;
  logic img_out_empty = 1'b1;
  logic [7:0] img_out_dout = 8'h00;
  logic [DWT-1:0] data_in = '0;
  logic [15:0] width_in = 16'd0, height_in = 16'd0;
  logic [3:0] interlaced_in = 4'd0;
  logic read, image_wr_en, img_out_rd_en, write, end_of_video_out, vip_ctrl_send;
  logic err_short, err_long;
  logic [DWT-1:0] image_din, data_out;
  logic [15:0] width_out, height_out;
  logic [3:0] interlaced_out;

  int checks = 0, errors = 0;
  int cyc = 0, push_cnt = 0, wr_cnt = 0, acc_cnt = 0, send_cnt = 0;
  int send_cyc = 0, first_read = -1, sends_at_read = 0;
  logic [15:0] sw = 16'd0, sh = 16'd0;
  logic [DWT-1:0] plog [0:63];
  logic [DWT-1:0] wlog [0:63];
  logic eovlog [0:63];
  logic [7:0] q [$];
  logic stall_tgl = 1'b0;

  canny_frame_sequencer dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .read(read), .data_in(data_in),
    .end_of_video(end_of_video), .width_in(width_in), .height_in(height_in),
    .interlaced_in(interlaced_in), .vip_ctrl_valid(vip_ctrl_valid),
    .image_full(image_full), .image_wr_en(image_wr_en), .image_din(image_din),
    .img_out_empty(img_out_empty), .img_out_rd_en(img_out_rd_en),
    .img_out_dout(img_out_dout), .stall_out(stall_out), .write(write),
    .data_out(data_out), .end_of_video_out(end_of_video_out),
    .width_out(width_out), .height_out(height_out), .interlaced_out(interlaced_out),
    .vip_ctrl_busy(vip_ctrl_busy), .vip_ctrl_send(vip_ctrl_send),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stall_tgl) stall_out = ~stall_out;

  // Passthrough pipeline model and transaction monitor.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (img_out_rd_en && q.size() > 0) q.delete(0);
      if (image_wr_en) begin
        if (push_cnt < 64) plog[push_cnt] = image_din;
        push_cnt++;
        q.push_back(image_din[7:0]);
      end
      if (write && !stall_out) begin
        if (wr_cnt < 64) begin
          wlog[wr_cnt]   = data_out;
          eovlog[wr_cnt] = end_of_video_out;
        end
        wr_cnt++;
      end
      if (read && !stall_in) acc_cnt++;
      if (vip_ctrl_send) begin
        send_cnt++;
        send_cyc = cyc;
        sw = width_out;
        sh = height_out;
      end
      if (read && first_read < 0) begin
        first_read    = cyc;
        sends_at_read = send_cnt;
      end
    end
    img_out_empty <= (q.size() == 0);
    img_out_dout  <= (q.size() > 0) ? q[0] : 8'h00;
  end

  task automatic send_beat(input logic [7:0] b, input logic eov);
    int t = 0;
    data_in      = {b, b, b};
    end_of_video = eov;
    stall_in     = 1'b0;
    while (!read && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout got read=%b want read=1", read);
    end
    @(negedge clk);
    stall_in     = 1'b1;
    end_of_video = 1'b0;
  endtask

  task automatic start_frame;
    push_cnt = 0; wr_cnt = 0; acc_cnt = 0; send_cnt = 0; first_read = -1;
    vip_ctrl_busy = 1'b0;
  endtask

  task automatic run_frame(input int n, input int base);
    start_frame();
    for (int k = 0; k < n; k++) send_beat(8'(base + k), k == n - 1);
    vip_ctrl_busy = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({read, image_wr_en, img_out_rd_en, write, end_of_video_out, vip_ctrl_send,
         err_short, err_long} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000", {read, image_wr_en, img_out_rd_en,
               write, end_of_video_out, vip_ctrl_send, err_short, err_long});
    end
    checks++;
    if (image_din !== 24'h0 || data_out !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got din=%h dout=%h want 0", image_din, data_out);
    end
    checks++;
    if (width_out !== 16'd640 || height_out !== 16'd480 || interlaced_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_geom got %0d x %0d il %0d want 640 x 480 il 0",
               width_out, height_out, interlaced_out);
    end
    width_in = 16'd4; height_in = 16'd2; interlaced_in = 4'd3;
    vip_ctrl_valid = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    vip_ctrl_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (width_out !== 16'd4 || height_out !== 16'd2 || interlaced_out !== 4'd3) begin
      errors++;
      $display("FAIL geom_apply got %0d x %0d il %0d want 4 x 2 il 3",
               width_out, height_out, interlaced_out);
    end
  endtask

  task automatic test_basic;
    int bad = 0, eovs = 0;
    run_frame(8, 8'h10);
    checks++;
    if (push_cnt !== 8) begin errors++; $display("FAIL basic_pushes got %0d want 8", push_cnt); end
    checks++;
    if (wr_cnt !== 8) begin errors++; $display("FAIL basic_writes got %0d want 8", wr_cnt); end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      b = 8'(8'h10 + k);
      if (wlog[k] !== {b, b, b}) bad++;
      if (eovlog[k]) eovs++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_data got %0d bad beats want 0", bad); end
    checks++;
    if (eovs != 1 || eovlog[7] !== 1'b1) begin
      errors++;
      $display("FAIL basic_eov got count %0d last %b want 1 1", eovs, eovlog[7]);
    end
    checks++;
    if (sends_at_read !== 1 || first_read !== send_cyc + 1) begin
      errors++;
      $display("FAIL basic_send got sends %0d read_cyc %0d want 1 %0d",
               sends_at_read, first_read, send_cyc + 1);
    end
  endtask

  task automatic test_short;
    int bad = 0;
    run_frame(5, 8'h20);
    checks++;
    if (err_short !== 1'b1 || err_long !== 1'b0) begin
      errors++;
      $display("FAIL short_err got short %b long %b want 1 0", err_short, err_long);
    end
    checks++;
    if (push_cnt !== 8 || plog[5] !== 24'h0 || plog[6] !== 24'h0 || plog[7] !== 24'h0) begin
      errors++;
      $display("FAIL short_pad got pushes %0d tail %h %h %h want 8 zeros",
               push_cnt, plog[5], plog[6], plog[7]);
    end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      b = (k < 5) ? 8'(8'h20 + k) : 8'h00;
      if (wlog[k] !== {b, b, b}) bad++;
    end
    checks++;
    if (wr_cnt !== 8 || bad != 0) begin
      errors++;
      $display("FAIL short_out got %0d beats %0d bad want 8 0", wr_cnt, bad);
    end
    checks++;
    if (eovlog[7] !== 1'b1 || eovlog[4] !== 1'b0) begin
      errors++;
      $display("FAIL short_eov got b5 %b b8 %b want 0 1", eovlog[4], eovlog[7]);
    end
    send_cnt = 0;
    vip_ctrl_busy = 1'b0;
    repeat (3) @(negedge clk);
    vip_ctrl_busy = 1'b1;
    checks++;
    if (send_cnt !== 1) begin errors++; $display("FAIL short_idle got sends %0d want 1", send_cnt); end
  endtask

  task automatic test_long;
    run_frame(10, 8'h30);
    checks++;
    if (push_cnt !== 8) begin errors++; $display("FAIL long_pushes got %0d want 8", push_cnt); end
    checks++;
    if (err_long !== 1'b1) begin errors++; $display("FAIL long_err got %b want 1", err_long); end
    checks++;
    if (acc_cnt !== 10) begin errors++; $display("FAIL long_accept got %0d want 10", acc_cnt); end
    checks++;
    if (wr_cnt !== 8 || wlog[7] !== 24'h373737 || eovlog[7] !== 1'b1) begin
      errors++;
      $display("FAIL long_out got %0d beats last %h eov %b want 8 373737 1",
               wr_cnt, wlog[7], eovlog[7]);
    end
  endtask

  task automatic test_stall_out;
    int bad = 0;
    stall_tgl = 1'b1;
    run_frame(8, 0);
    stall_tgl = 1'b0;
    stall_out = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      b = 8'(k);
      if (wlog[k] !== {b, b, b}) bad++;
    end
    checks++;
    if (wr_cnt !== 8) begin errors++; $display("FAIL stall_count got %0d want 8", wr_cnt); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_data got %0d bad want 0", bad); end
    checks++;
    if (eovlog[7] !== 1'b1 || eovlog[6] !== 1'b0) begin
      errors++;
      $display("FAIL stall_eov got b7 %b b8 %b want 0 1", eovlog[6], eovlog[7]);
    end
  endtask

  task automatic test_geom_midframe;
    start_frame();
    for (int k = 0; k < 3; k++) send_beat(8'(8'h40 + k), 1'b0);
    width_in = 16'd8; height_in = 16'd4; vip_ctrl_valid = 1'b1;
    @(negedge clk);
    vip_ctrl_valid = 1'b0;
    for (int k = 3; k < 8; k++) send_beat(8'(8'h40 + k), k == 7);
    vip_ctrl_busy = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (push_cnt !== 8 || wr_cnt !== 8) begin
      errors++;
      $display("FAIL geom_cur got pushes %0d writes %0d want 8 8", push_cnt, wr_cnt);
    end
    checks++;
    if (eovlog[7] !== 1'b1) begin errors++; $display("FAIL geom_eov got %b want 1", eovlog[7]); end
    send_cnt = 0;
    vip_ctrl_busy = 1'b0;
    repeat (3) @(negedge clk);
    vip_ctrl_busy = 1'b1;
    checks++;
    if (send_cnt !== 1 || sw !== 16'd8 || sh !== 16'd4) begin
      errors++;
      $display("FAIL geom_next got sends %0d %0d x %0d want 1 8 x 4", send_cnt, sw, sh);
    end
  endtask

  task automatic test_full_then_reset;
    int bad = 0;
    for (int k = 0; k < 3; k++) send_beat(8'(8'h50 + k), 1'b0);
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL full_pre_read got %b want 1", read); end
    image_full = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (read !== 1'b0 || image_wr_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_read got %0d bad cycles want 0", bad); end
    rst = 1'b1;
    #1;
    checks++;
    if ({read, image_wr_en, img_out_rd_en, write, end_of_video_out, vip_ctrl_send,
         err_short, err_long} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_ctrl got %b want 00000000", {read, image_wr_en, img_out_rd_en,
               write, end_of_video_out, vip_ctrl_send, err_short, err_long});
    end
    checks++;
    if (image_din !== 24'h0 || data_out !== 24'h0) begin
      errors++;
      $display("FAIL midrst_data got din=%h dout=%h want 0", image_din, data_out);
    end
    checks++;
    if (width_out !== 16'd640 || height_out !== 16'd480 || interlaced_out !== 4'd0) begin
      errors++;
      $display("FAIL midrst_geom got %0d x %0d il %0d want 640 x 480 il 0",
               width_out, height_out, interlaced_out);
    end
    image_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_stall_out();
    test_geom_midframe();
    test_full_then_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
